// File: rtl/cache_miss_fill_if.sv
// Bus bundle for the miss-handling/fill stage: miss intake, L2 request and
// response, LRU victim lookup and the cache tag/data update ports.
// The master modport is the fill stage itself. The slave modport is the
// surrounding core, the L2 and the cache array.
interface cache_miss_fill_if #(
  parameter int TAG_W     = 22,
  parameter int SET_W     = 4,
  parameter int WAY_W     = 2,
  parameter int ID_W      = 2,
  parameter int LINE_BITS = 512
);
  logic                   miss_en;
  logic [TAG_W-1:0]       miss_tag;
  logic [SET_W-1:0]       miss_set;
  logic                   miss_ready;
  logic [ID_W-1:0]        miss_id;

  logic                   l2_req_valid;
  logic                   l2_req_ready;
  logic [TAG_W+SET_W-1:0] l2_req_addr;
  logic [ID_W-1:0]        l2_req_id;

  logic                   l2_rsp_valid;
  logic [ID_W-1:0]        l2_rsp_id;
  logic [LINE_BITS-1:0]   l2_rsp_data;

  logic                   lru_fill_en;
  logic [SET_W-1:0]       lru_fill_set;
  logic [WAY_W-1:0]       lru_fill_way_idx;

  logic                   update_tag_en;
  logic [WAY_W-1:0]       update_tag_way_idx;
  logic [SET_W-1:0]       update_tag_set_idx;
  logic [TAG_W-1:0]       update_tag;
  logic                   update_tag_valid;
  logic                   update_data_en;
  logic [WAY_W-1:0]       update_data_way_idx;
  logic [SET_W-1:0]       update_data_set_idx;
  logic [LINE_BITS-1:0]   update_data;

  logic                   fill_done;
  logic [ID_W-1:0]        fill_done_id;

  modport master (
    input  miss_en, miss_tag, miss_set,
    output miss_ready, miss_id,
    output l2_req_valid, l2_req_addr, l2_req_id,
    input  l2_req_ready,
    input  l2_rsp_valid, l2_rsp_id, l2_rsp_data,
    output lru_fill_en, lru_fill_set,
    input  lru_fill_way_idx,
    output update_tag_en, update_tag_way_idx, update_tag_set_idx, update_tag, update_tag_valid,
    output update_data_en, update_data_way_idx, update_data_set_idx, update_data,
    output fill_done, fill_done_id
  );

  modport slave (
    output miss_en, miss_tag, miss_set,
    input  miss_ready, miss_id,
    input  l2_req_valid, l2_req_addr, l2_req_id,
    output l2_req_ready,
    output l2_rsp_valid, l2_rsp_id, l2_rsp_data,
    input  lru_fill_en, lru_fill_set,
    output lru_fill_way_idx,
    input  update_tag_en, update_tag_way_idx, update_tag_set_idx, update_tag, update_tag_valid,
    input  update_data_en, update_data_way_idx, update_data_set_idx, update_data,
    input  fill_done, fill_done_id
  );
endinterface

// File: rtl/cache_miss_fill.sv
// Miss-handling/fill stage. Tracks up to NUM_MISS outstanding line misses and
// merges duplicate misses to the same line. It issues one L2 read per unique
// line. Each L2 response runs through a two-stage fill: LRU lookup, then the
// tag/data write together with fill_done.
module cache_miss_fill #(
  parameter int NUM_WAYS             = 4,
  parameter int NUM_SETS             = 16,
  parameter int CACHE_LINE_TAG_WIDTH = 22,
  parameter int CACHE_LINE_BYTES     = 64,
  parameter int NUM_MISS             = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_miss_fill_if.master     bus
);
  localparam int NUM_WAYS_LOG    = $clog2(NUM_WAYS);
  localparam int NUM_SETS_LOG    = $clog2(NUM_SETS);
  localparam int CACHE_LINE_BITS = CACHE_LINE_BYTES * 8;
  localparam int MISS_ID_W       = $clog2(NUM_MISS);
  localparam int TAG_W           = CACHE_LINE_TAG_WIDTH;

  typedef enum logic [1:0] {E_IDLE, E_PEND, E_ISSUED, E_FILL} entry_state_t;

  entry_state_t                ent_state [NUM_MISS];
  logic [TAG_W-1:0]            ent_tag   [NUM_MISS];
  logic [NUM_SETS_LOG-1:0]     ent_set   [NUM_MISS];

  logic                        req_valid;
  logic [MISS_ID_W-1:0]        req_id;
  logic [TAG_W+NUM_SETS_LOG-1:0] req_addr;

  logic                        s2_valid;
  logic [MISS_ID_W-1:0]        s2_id;
  logic [TAG_W-1:0]            s2_tag;
  logic [NUM_SETS_LOG-1:0]     s2_set;
  logic [CACHE_LINE_BITS-1:0]  s2_data;

  logic                        hit, free_found, pend_found;
  logic [MISS_ID_W-1:0]        hit_id, free_id, pend_id;
  logic                        req_hs, req_load, alloc, rsp_accept;
  logic [NUM_WAYS_LOG-1:0]     fill_way;

  assign req_hs     = req_valid && bus.l2_req_ready;
  assign req_load   = !req_valid || req_hs;
  assign alloc      = bus.miss_en && !hit && free_found;
  assign rsp_accept = bus.l2_rsp_valid && !rst && (ent_state[bus.l2_rsp_id] == E_ISSUED);

  // Priority scans over the entries: line match for merging, lowest idle
  // entry for allocation, and lowest pending entry for the request register.
  // An entry in its final fill cycle (E_FILL) is already being written, so it
  // no longer matches and a new miss to that line gets its own entry.
  // The entry just handshaked is still E_PEND this cycle and must not be
  // picked up a second time.
  always_comb begin
    hit        = 1'b0;
    hit_id     = '0;
    free_found = 1'b0;
    free_id    = '0;
    pend_found = 1'b0;
    pend_id    = '0;
    for (int i = 0; i < NUM_MISS; i++) begin
      if (!hit && (ent_state[i] == E_PEND || ent_state[i] == E_ISSUED) &&
          ent_tag[i] == bus.miss_tag && ent_set[i] == bus.miss_set) begin
        hit    = 1'b1;
        hit_id = MISS_ID_W'(i);
      end
      if (!free_found && ent_state[i] == E_IDLE) begin
        free_found = 1'b1;
        free_id    = MISS_ID_W'(i);
      end
      if (!pend_found && ent_state[i] == E_PEND &&
          !(req_hs && req_id == MISS_ID_W'(i))) begin
        pend_found = 1'b1;
        pend_id    = MISS_ID_W'(i);
      end
    end
  end

  assign bus.miss_ready   = hit || free_found;
  assign bus.miss_id      = hit ? hit_id : free_id;

  assign bus.l2_req_valid = req_valid;
  assign bus.l2_req_addr  = req_addr;
  assign bus.l2_req_id    = req_id;

  assign bus.lru_fill_en  = rsp_accept;
  assign bus.lru_fill_set = rsp_accept ? ent_set[bus.l2_rsp_id] : '0;

  // The LRU victim arrives combinationally in the cycle after the lookup, so
  // it is passed straight through while stage 2 is active.
  assign fill_way                = s2_valid ? bus.lru_fill_way_idx : '0;
  assign bus.update_tag_en       = s2_valid;
  assign bus.update_data_en      = s2_valid;
  assign bus.update_tag_valid    = s2_valid;
  assign bus.update_tag_way_idx  = fill_way;
  assign bus.update_data_way_idx = fill_way;
  assign bus.update_tag_set_idx  = s2_set;
  assign bus.update_data_set_idx = s2_set;
  assign bus.update_tag          = s2_tag;
  assign bus.update_data         = s2_data;
  assign bus.fill_done           = s2_valid;
  assign bus.fill_done_id        = s2_id;

  // Entry lifecycle, L2 request register and fill stage-2 register.
  // Each entry can only take the transition that belongs to its current
  // state, so the per-entry updates never collide. Reset drops every entry
  // and any fill in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_MISS; i++) begin
        ent_state[i] <= E_IDLE;
        ent_tag[i]   <= '0;
        ent_set[i]   <= '0;
      end
      req_valid <= 1'b0;
      req_id    <= '0;
      req_addr  <= '0;
      s2_valid  <= 1'b0;
      s2_id     <= '0;
      s2_tag    <= '0;
      s2_set    <= '0;
      s2_data   <= '0;
    end else begin
      for (int i = 0; i < NUM_MISS; i++) begin
        case (ent_state[i])
          E_IDLE: begin
            if (alloc && free_id == MISS_ID_W'(i)) begin
              ent_state[i] <= E_PEND;
              ent_tag[i]   <= bus.miss_tag;
              ent_set[i]   <= bus.miss_set;
            end
          end
          E_PEND: begin
            if (req_hs && req_id == MISS_ID_W'(i)) ent_state[i] <= E_ISSUED;
          end
          E_ISSUED: begin
            if (rsp_accept && bus.l2_rsp_id == MISS_ID_W'(i)) ent_state[i] <= E_FILL;
          end
          E_FILL:  ent_state[i] <= E_IDLE;
          default: ent_state[i] <= E_IDLE;
        endcase
      end

      if (req_load) begin
        req_valid <= pend_found;
        if (pend_found) begin
          req_id   <= pend_id;
          req_addr <= {ent_tag[pend_id], ent_set[pend_id]};
        end
      end

      s2_valid <= rsp_accept;
      if (rsp_accept) begin
        s2_id   <= bus.l2_rsp_id;
        s2_tag  <= ent_tag[bus.l2_rsp_id];
        s2_set  <= ent_set[bus.l2_rsp_id];
        s2_data <= bus.l2_rsp_data;
      end
    end
  end

  // A response for an entry that is not waiting on L2 is dropped. This flags
  // it in simulation, which typically means a stale response after reset.
  always_ff @(posedge clk) begin
    if (!rst && bus.l2_rsp_valid) begin
      assert (ent_state[bus.l2_rsp_id] == E_ISSUED)
        else $warning("cache_miss_fill: dropped L2 response for id %0d", bus.l2_rsp_id);
    end
  end
endmodule

// File: tb/tb_cache_miss_fill.sv
// Directed bench for cache_miss_fill. Inputs are driven 1ns after each rising
// edge and outputs are sampled 1ns after that, well away from the next edge.
module tb_cache_miss_fill;
  localparam int TAG_W     = 22;
  localparam int SET_W     = 4;
  localparam int WAY_W     = 2;
  localparam int ID_W      = 2;
  localparam int LINE_BITS = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   hs_count   = 0;
  int   hs_base;

  logic [LINE_BITS-1:0] d1, d2, d3, d4;

  cache_miss_fill_if #(.TAG_W(TAG_W), .SET_W(SET_W), .WAY_W(WAY_W),
                       .ID_W(ID_W), .LINE_BITS(LINE_BITS)) bus ();

  cache_miss_fill dut (.clk(clk), .rst(rst), .bus(bus));

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Counts every L2 request handshake so merges can be verified.
  always @(posedge clk) begin
    if (bus.l2_req_valid && bus.l2_req_ready) hs_count++;
  end

  task automatic checkOutput(input string name, input logic [LINE_BITS-1:0] got,
                             input logic [LINE_BITS-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic men, input logic [TAG_W-1:0] tag,
                               input logic [SET_W-1:0] set, input logic rv,
                               input logic [ID_W-1:0] rid, input logic [LINE_BITS-1:0] rdata);
    @(posedge clk);
    #1;
    bus.miss_en      = men;
    bus.miss_tag     = tag;
    bus.miss_set     = set;
    bus.l2_rsp_valid = rv;
    bus.l2_rsp_id    = rid;
    bus.l2_rsp_data  = rdata;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    d1 = {16{32'hA5A5_0001}};
    d2 = {16{32'h5A5A_0002}};
    d3 = {16{32'h1357_0003}};
    d4 = {16{32'h2468_0004}};
    bus.miss_en          = 1'b0;
    bus.miss_tag         = '0;
    bus.miss_set         = '0;
    bus.l2_req_ready     = 1'b1;
    bus.l2_rsp_valid     = 1'b0;
    bus.l2_rsp_id        = '0;
    bus.l2_rsp_data      = '0;
    bus.lru_fill_way_idx = '0;

    $display("[TB] reset");
    idleCycle();
    idleCycle();
    checkOutput("rst_miss_ready", bus.miss_ready, 1);
    checkOutput("rst_req_valid", bus.l2_req_valid, 0);
    checkOutput("rst_update_en", bus.update_tag_en, 0);
    checkOutput("rst_fill_done", bus.fill_done, 0);
    checkOutput("rst_lru_en", bus.lru_fill_en, 0);
    rst = 1'b0;

    $display("[TB] single miss and fill");
    applyStimulus(1'b1, 22'h1234, 4'd3, 1'b0, '0, '0);
    checkOutput("t1_ready", bus.miss_ready, 1);
    checkOutput("t1_miss_id", bus.miss_id, 0);
    idleCycle();
    checkOutput("t1_req_not_yet", bus.l2_req_valid, 0);
    idleCycle();
    checkOutput("t1_req_valid", bus.l2_req_valid, 1);
    checkOutput("t1_req_addr", bus.l2_req_addr, 26'h12343);
    checkOutput("t1_req_id", bus.l2_req_id, 0);
    idleCycle();
    checkOutput("t1_req_drop", bus.l2_req_valid, 0);
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd0, d1);
    checkOutput("t1_lru_en", bus.lru_fill_en, 1);
    checkOutput("t1_lru_set", bus.lru_fill_set, 3);
    bus.lru_fill_way_idx = 2'd2;
    applyStimulus(1'b1, 22'h1234, 4'd3, 1'b0, '0, '0);
    checkOutput("t1_tag_en", bus.update_tag_en, 1);
    checkOutput("t1_data_en", bus.update_data_en, 1);
    checkOutput("t1_tag_way", bus.update_tag_way_idx, 2);
    checkOutput("t1_data_way", bus.update_data_way_idx, 2);
    checkOutput("t1_tag_set", bus.update_tag_set_idx, 3);
    checkOutput("t1_data_set", bus.update_data_set_idx, 3);
    checkOutput("t1_tag", bus.update_tag, 22'h1234);
    checkOutput("t1_tag_valid", bus.update_tag_valid, 1);
    checkOutput("t1_data", bus.update_data, d1);
    checkOutput("t1_fill_done", bus.fill_done, 1);
    checkOutput("t1_fill_id", bus.fill_done_id, 0);
    checkOutput("t1_s2_nomatch_ready", bus.miss_ready, 1);
    checkOutput("t1_s2_nomatch_id", bus.miss_id, 1);
    idleCycle();
    checkOutput("t1_done_pulse", bus.fill_done, 0);
    checkOutput("t1_tag_en_off", bus.update_tag_en, 0);
    idleCycle();
    checkOutput("t1_refill_req", bus.l2_req_valid, 1);
    checkOutput("t1_refill_id", bus.l2_req_id, 1);
    checkOutput("t1_refill_addr", bus.l2_req_addr, 26'h12343);
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd1, d1);
    idleCycle();
    checkOutput("t1_refill_done_id", bus.fill_done_id, 1);
    idleCycle();

    $display("[TB] merged duplicate miss");
    hs_base = hs_count;
    applyStimulus(1'b1, 22'h55, 4'd7, 1'b0, '0, '0);
    checkOutput("t2_first_id", bus.miss_id, 0);
    idleCycle();
    idleCycle();
    applyStimulus(1'b1, 22'h55, 4'd7, 1'b0, '0, '0);
    checkOutput("t2_second_ready", bus.miss_ready, 1);
    checkOutput("t2_second_id", bus.miss_id, 0);
    idleCycle();
    idleCycle();
    idleCycle();
    checkOutput("t2_one_request", hs_count - hs_base, 1);
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd0, d2);
    idleCycle();
    idleCycle();

    $display("[TB] full queue");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, TAG_W'(22'h100 + i), SET_W'(i), 1'b0, '0, '0);
      checkOutput("t3_alloc_id", bus.miss_id, i);
    end
    applyStimulus(1'b1, 22'h200, 4'd9, 1'b0, '0, '0);
    checkOutput("t3_full_ready", bus.miss_ready, 0);
    applyStimulus(1'b1, 22'h100, 4'd0, 1'b0, '0, '0);
    checkOutput("t3_repeat_ready", bus.miss_ready, 1);
    checkOutput("t3_repeat_id", bus.miss_id, 0);
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd0, d2);
    checkOutput("t3_lru_set0", bus.lru_fill_set, 0);
    applyStimulus(1'b1, 22'h200, 4'd9, 1'b0, '0, '0);
    checkOutput("t3_no_bypass_ready", bus.miss_ready, 0);
    checkOutput("t3_done0", bus.fill_done, 1);
    applyStimulus(1'b1, 22'h200, 4'd9, 1'b0, '0, '0);
    checkOutput("t3_fifth_ready", bus.miss_ready, 1);
    checkOutput("t3_fifth_id", bus.miss_id, 0);
    idleCycle();
    idleCycle();
    checkOutput("t3_fifth_req_id", bus.l2_req_id, 0);
    checkOutput("t3_fifth_req_addr", bus.l2_req_addr, 26'h2009);

    $display("[TB] back-to-back responses");
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd1, d3);
    checkOutput("t5_lru_set_a", bus.lru_fill_set, 1);
    bus.lru_fill_way_idx = 2'd3;
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd0, d4);
    checkOutput("t5_en_a", bus.update_data_en, 1);
    checkOutput("t5_way_a", bus.update_data_way_idx, 3);
    checkOutput("t5_set_a", bus.update_tag_set_idx, 1);
    checkOutput("t5_tag_a", bus.update_tag, 22'h101);
    checkOutput("t5_data_a", bus.update_data, d3);
    checkOutput("t5_id_a", bus.fill_done_id, 1);
    checkOutput("t5_lru_en_b", bus.lru_fill_en, 1);
    checkOutput("t5_lru_set_b", bus.lru_fill_set, 9);
    bus.lru_fill_way_idx = 2'd1;
    idleCycle();
    checkOutput("t5_en_b", bus.update_tag_en, 1);
    checkOutput("t5_way_b", bus.update_tag_way_idx, 1);
    checkOutput("t5_set_b", bus.update_data_set_idx, 9);
    checkOutput("t5_tag_b", bus.update_tag, 22'h200);
    checkOutput("t5_data_b", bus.update_data, d4);
    checkOutput("t5_id_b", bus.fill_done_id, 0);
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd2, d1);
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd3, d1);
    idleCycle();
    idleCycle();

    $display("[TB] request held under backpressure");
    applyStimulus(1'b1, 22'h3A, 4'd2, 1'b0, '0, '0);
    checkOutput("t4_id_a", bus.miss_id, 0);
    applyStimulus(1'b1, 22'h3B, 4'd5, 1'b0, '0, '0);
    checkOutput("t4_id_b", bus.miss_id, 1);
    idleCycle();
    checkOutput("t4_first_req_id", bus.l2_req_id, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k == 2, 22'h3C, 4'd6, k == 0, 2'd0, d1);
      if (k == 0) bus.l2_req_ready = 1'b0;
      checkOutput("t4_hold_valid", bus.l2_req_valid, 1);
      checkOutput("t4_hold_id", bus.l2_req_id, 1);
      checkOutput("t4_hold_addr", bus.l2_req_addr, 26'h3B5);
      if (k == 2) checkOutput("t4_low_alloc_id", bus.miss_id, 0);
    end
    bus.l2_req_ready = 1'b1;
    idleCycle();
    checkOutput("t4_next_id", bus.l2_req_id, 0);
    checkOutput("t4_next_addr", bus.l2_req_addr, 26'h3C6);
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd1, d1);
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd0, d1);
    idleCycle();
    idleCycle();

    $display("[TB] reset with an issued entry");
    applyStimulus(1'b1, 22'h66, 4'd4, 1'b0, '0, '0);
    idleCycle();
    idleCycle();
    checkOutput("t6_req_valid", bus.l2_req_valid, 1);
    idleCycle();
    rst = 1'b1;
    idleCycle();
    rst = 1'b0;
    #1;
    checkOutput("t6_req_cleared", bus.l2_req_valid, 0);
    checkOutput("t6_ready", bus.miss_ready, 1);
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd0, d2);
    checkOutput("t6_no_lru", bus.lru_fill_en, 0);
    idleCycle();
    checkOutput("t6_no_update", bus.update_tag_en, 0);
    checkOutput("t6_no_data_update", bus.update_data_en, 0);
    checkOutput("t6_no_done", bus.fill_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
